seg_scan: RTL and testbench
===========================

SEG_SCAN -- requirements
Module: seg_scan

Interface
REQ-001 Parameter SCAN_DIV, default 100000, clk_in cycles per digit slot; legal range 1..2^20.
REQ-002 clk_in  input  1  system clock; all state is on the rising edge.
REQ-003 RST  input  1  reset, asynchronous, active-high.
REQ-004 value  input  32  word to display, 8 hex nibbles.
REQ-005 SEG  output  8  segment cathodes, active-low; SEG[6:0]=g..a, SEG[7]=dp.
REQ-006 AN  output  8  digit anodes, active-low, one-hot; AN[k] selects nibble value[4k+3:4k].
REQ-007 frame_tick  output  1  one-cycle pulse when the shadow register reloads.

Function
REQ-008 The prescaler SHALL count 0..SCAN_DIV-1, then wrap to 0; slot_tick is asserted when the count equals SCAN_DIV-1.
REQ-009 The 3-bit digit index SHALL increment on slot_tick, wrapping 7->0.
REQ-010 The 32-bit shadow register SHALL load value on the cycle where slot_tick=1 and index=7 (frame boundary); otherwise it holds.
REQ-011 frame_tick SHALL be registered and high exactly in the cycle after the shadow reload.
REQ-012 Changes of value mid-frame SHALL have no visible effect until the next frame boundary (tear-free).
REQ-013 AN and SEG SHALL be registered, each reflecting index/shadow with one cycle of latency.
REQ-014 AN SHALL be ~(8'b1<<index); exactly one bit is low outside reset.
REQ-015 SEG SHALL use this hex table: 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8, 8 80, 9 90, A 88, b 83, C C6, d A1, E 86, F 8E; dp is always off.
REQ-016 With SCAN_DIV=1, slot_tick SHALL be high every cycle and the index SHALL advance every cycle.
REQ-017 A full refresh frame SHALL take 8*SCAN_DIV cycles.

Reset
REQ-018 While RST=1, these SHALL hold: prescaler=0, index=0, shadow=0, AN=8'hFF, SEG=8'hFF, frame_tick=0.
REQ-019 RST asserted mid-frame SHALL force the REQ-018 values immediately, without waiting for clk_in.
REQ-020 On the first clock after RST deasserts: AN=8'hFE, SEG=8'hC0 (digit 0 of zeroed shadow).

Configuration
REQ-021 Macro SEG_BLANK_EN SHALL control leading-zero blanking.
REQ-022 With SEG_BLANK_EN defined, a digit k>0 whose nibble and all higher nibbles of shadow are zero SHALL drive AN=8'hFF and SEG=8'hFF during its slot.
REQ-023 Digit 0 SHALL never be blanked.
REQ-024 Without SEG_BLANK_EN, all 8 digits SHALL always be driven, including zeros; the blanking logic is absent.

Structure
REQ-025 Package seg_pkg SHALL hold the 16-entry hex-to-segment table, SEG_OFF=8'hFF, AN_OFF=8'hFF, and the index width constant.
REQ-026 Sub-module seg_hex_dec (combinational, 4-bit nibble -> 8-bit SEG) SHALL be instantiated once inside seg_scan.
REQ-027 Prescaler, index, shadow, blanking mask and output registers SHALL reside in seg_scan.

Verification (bench SCAN_DIV=4)
REQ-028 Reset release, value=32'h0 -> AN sequence FE,FD,FB,F7,EF,DF,BF,7F, 4 cycles each; SEG=C0 throughout; frame_tick pulses every 32 cycles.
REQ-029 value=32'h89ABCDEF applied before a frame boundary -> next frame SEG per digit 0..7 = 8E,86,A1,C6,83,88,90,80.
REQ-030 value changed from 32'h11111111 to 32'h22222222 while index=3 -> digits 3..7 still show F9; A4 appears only from the next frame's digit 0.
REQ-031 RST pulsed mid-slot at index=5 -> AN=FF, SEG=FF, frame_tick=0 in the same cycle without a clk_in edge; restart at AN=FE after release.
REQ-032 With SEG_BLANK_EN and value=32'h000000A5 -> digits 0,1 show 92,88; digits 2..7 drive AN=FF, SEG=FF; without the macro they show C0.
REQ-033 SCAN_DIV=1 build -> AN advances every cycle; frame_tick period is 8 cycles.

Source files
------------

// File: rtl/seg_pkg.sv
// seg_pkg -- shared constants for the seg_scan display multiplexer.
//   IDX_W    : width of the digit index (8 digits)
//   NUM_DIG  : number of digits scanned per frame
//   SEG_OFF  : all segments dark (active-low cathodes)
//   AN_OFF   : all anodes disabled (active-low anodes)
//   HEX_SEG  : hex nibble -> {dp,g..a} pattern, active-low, dp off
//   an_sel() : active-low one-hot anode pattern for a digit index
package seg_pkg;
  localparam int IDX_W   = 3;
  localparam int NUM_DIG = 8;

  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [7:0] AN_OFF  = 8'hFF;

  // Entry [n] is the pattern for nibble n; concatenation lists F down to 0.
  localparam logic [15:0][7:0] HEX_SEG = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  function automatic logic [7:0] an_sel(input logic [IDX_W-1:0] idx);
    return ~(8'b1 << idx);
  endfunction
endpackage

// File: rtl/seg_hex_dec.sv
// seg_hex_dec -- combinational hex nibble to 7-segment decoder.
//   nib_i [3:0] : nibble to display
//   seg_o [7:0] : active-low segments {dp,g,f,e,d,c,b,a}, dp always off
module seg_hex_dec
  import seg_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [7:0] seg_o
);
  assign seg_o = HEX_SEG[nib_i];
endmodule

// File: rtl/seg_scan.sv
// seg_scan -- 8-digit multiplexed 7-segment display scanner with a
// tear-free shadow register reloaded once per refresh frame.
//   SCAN_DIV       : clk_in cycles per digit slot (1..2^20)
//   clk_in         : system clock, rising edge
//   RST            : asynchronous active-high reset
//   value [31:0]   : word to display, 8 hex nibbles
//   SEG   [7:0]    : active-low cathodes, [6:0]=g..a, [7]=dp
//   AN    [7:0]    : active-low one-hot anodes, AN[k] shows value[4k+3:4k]
//   frame_tick     : one-cycle pulse the cycle after the shadow reload
// Optional build macro SEG_BLANK_EN enables leading-zero blanking
// (digit 0 is never blanked).
module seg_scan
  import seg_pkg::*;
#(
  parameter int SCAN_DIV = 100000
) (
  input  logic        clk_in,
  input  logic        RST,
  input  logic [31:0] value,
  output logic [7:0]  SEG,
  output logic [7:0]  AN,
  output logic        frame_tick
);
  localparam int                CNT_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_MAX = IDX_W'(NUM_DIG - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [31:0]      shadow_q, shadow_d;
  logic [7:0]       an_q, an_d;
  logic [7:0]       seg_q, seg_d;
  logic             ft_q, ft_d;

  logic       slot_tick;
  logic       frame_bnd;
  logic [3:0] nib;
  logic [7:0] seg_dig;
  logic       blank;

  assign slot_tick = (cnt_q == CNT_MAX);
  assign frame_bnd = slot_tick && (idx_q == IDX_MAX);

  assign cnt_d    = slot_tick ? '0 : cnt_q + 1'b1;
  assign idx_d    = slot_tick ? idx_q + 1'b1 : idx_q;  // wraps 7->0
  // Shadow only moves at the frame boundary so a frame never mixes words.
  assign shadow_d = frame_bnd ? value : shadow_q;
  assign ft_d     = frame_bnd;

  assign nib = shadow_q[{idx_q, 2'b00} +: 4];

  seg_hex_dec u_dec (
    .nib_i (nib),
    .seg_o (seg_dig)
  );

`ifdef SEG_BLANK_EN
  // blank_mask[k]: nibble k and every nibble above it are zero.
  logic [NUM_DIG-1:0] blank_mask;
  assign blank_mask[0] = 1'b0;
  for (genvar k = 1; k < NUM_DIG; k++) begin : g_blank
    assign blank_mask[k] = (shadow_q[31:4*k] == '0);
  end
  assign blank = blank_mask[idx_q];
`else
  assign blank = 1'b0;
`endif

  assign an_d  = blank ? AN_OFF  : an_sel(idx_q);
  assign seg_d = blank ? SEG_OFF : seg_dig;

  always_ff @(posedge clk_in or posedge RST) begin
    if (RST) begin
      cnt_q    <= '0;
      idx_q    <= '0;
      shadow_q <= '0;
      an_q     <= AN_OFF;
      seg_q    <= SEG_OFF;
      ft_q     <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
      ft_q     <= ft_d;
    end
  end

  assign AN         = an_q;
  assign SEG        = seg_q;
  assign frame_tick = ft_q;
endmodule

// File: tb/tb_seg_scan.sv
// tb_seg_scan -- directed scoreboard bench for seg_scan (SCAN_DIV=4 main
// instance, SCAN_DIV=1 secondary instance sharing clock and reset).
module tb_seg_scan;
  typedef struct packed {
    logic [7:0] an;
    logic [7:0] seg;
    logic       ft;
    int         k;
  } exp_t;

`ifdef SEG_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        RST;
  logic [31:0] value;
  logic [31:0] value1;
  logic [7:0]  SEG, AN, SEG1, AN1;
  logic        frame_tick, frame_tick1;

  int n_checks = 0;
  int n_fail   = 0;
  int k;
  bit mon_en;
  bit ph1;
  exp_t q[$];
  exp_t q1[$];
  logic [31:0] fw [8];

  logic [7:0] HEX [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                           8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  seg_scan #(.SCAN_DIV(4)) dut (
    .clk_in(clk), .RST(RST), .value(value),
    .SEG(SEG), .AN(AN), .frame_tick(frame_tick)
  );

  seg_scan #(.SCAN_DIV(1)) dut1 (
    .clk_in(clk), .RST(RST), .value(value1),
    .SEG(SEG1), .AN(AN1), .frame_tick(frame_tick1)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Expected outputs after the k-th clock edge since reset release.
  function automatic exp_t expect_at(input int kk, input int div, input logic [31:0] word);
    exp_t e;
    int d;
    logic [31:0] w;
    d = ((kk - 1) / div) % 8;
    w = word;
    e.an  = ~(8'b1 << d);
    e.seg = HEX[w[4*d +: 4]];
    if (BLANK && d > 0 && (w >> (4*d)) == 0) begin
      e.an  = 8'hFF;
      e.seg = 8'hFF;
    end
    e.ft = ((kk % (8 * div)) == 0);
    e.k  = kk;
    return e;
  endfunction

  task automatic run_to(input int k_end);
    while (k < k_end) begin
      @(posedge clk);
      #1;
      k++;
      q.push_back(expect_at(k, 4, fw[(k - 1) / 32]));
      if (ph1 && k <= 16) q1.push_back(expect_at(k, 1, 32'h0));
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (mon_en && q.size() > 0) begin
      e = q.pop_front();
      check($sformatf("AN k=%0d", e.k), {24'h0, AN}, {24'h0, e.an});
      check($sformatf("SEG k=%0d", e.k), {24'h0, SEG}, {24'h0, e.seg});
      check($sformatf("frame_tick k=%0d", e.k), {31'h0, frame_tick}, {31'h0, e.ft});
    end
    if (mon_en && q1.size() > 0) begin
      e = q1.pop_front();
      check($sformatf("div1 AN k=%0d", e.k), {24'h0, AN1}, {24'h0, e.an});
      check($sformatf("div1 frame_tick k=%0d", e.k), {31'h0, frame_tick1}, {31'h0, e.ft});
    end
  end

  initial begin
    RST = 1'b0; value = '0; value1 = '0; mon_en = 1'b0; ph1 = 1'b0; k = 0;
    for (int i = 0; i < 8; i++) fw[i] = '0;
    #2 RST = 1'b1;
    repeat (3) @(negedge clk);
    check("reset AN", {24'h0, AN}, 32'hFF);
    check("reset SEG", {24'h0, SEG}, 32'hFF);
    check("reset frame_tick", {31'h0, frame_tick}, 32'h0);
    check("reset div1 AN", {24'h0, AN1}, 32'hFF);

    // Frame words shown after release: two zero frames, then the words
    // latched at edges 64, 96 and 128.
    fw[2] = 32'h89ABCDEF;
    fw[3] = 32'h11111111;
    fw[4] = 32'h22222222;
    k = 0; ph1 = 1'b1; mon_en = 1'b1;
    RST = 1'b0;
    run_to(36);  value = 32'h89ABCDEF;
    run_to(70);  value = 32'h11111111;
    run_to(109); value = 32'h22222222;  // index 3 of the frame showing 1s
    run_to(150);                        // index 5, mid-slot

    @(negedge clk);
    #1 mon_en = 1'b0; ph1 = 1'b0;
    #1 RST = 1'b1;
    #1;
    check("async reset AN", {24'h0, AN}, 32'hFF);
    check("async reset SEG", {24'h0, SEG}, 32'hFF);
    check("async reset frame_tick", {31'h0, frame_tick}, 32'h0);
    repeat (2) @(negedge clk);
    check("held reset AN", {24'h0, AN}, 32'hFF);
    q.delete();
    q1.delete();

    for (int i = 0; i < 8; i++) fw[i] = '0;
    fw[1] = 32'h22222222;
    fw[2] = 32'h000000A5;
    k = 0; mon_en = 1'b1;
    RST = 1'b0;
    run_to(36); value = 32'h000000A5;
    run_to(96);

    @(negedge clk);
    #1 mon_en = 1'b0;
    check("scoreboard drained", q.size() + q1.size(), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
